// File: rtl/msk_demod_diff.sv
// Differential MSK demodulator, one I/Q sample per symbol strobe.
// Cross product Q*I_prev - I*Q_prev feeds hard bit, rounded/saturated soft value and a symbol counter.
module msk_demod_diff #(
    parameter int IQ_W       = 16,
    parameter int SOFT_W     = 8,
    parameter int SOFT_SHIFT = 24,
    parameter int INVERT     = 0,
    parameter int CNT_W      = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     sym_val_i,
    input  logic signed [IQ_W-1:0]   i_in,
    input  logic signed [IQ_W-1:0]   q_in,
    input  logic                     resync_i,
    output logic                     data_out,
    output logic signed [SOFT_W-1:0] soft_out,
    output logic                     sat_o,
    output logic                     data_val,
    output logic [CNT_W-1:0]         sym_cnt_o
);

    localparam int PW = 2 * IQ_W;
    localparam int DW = PW + 1;
    localparam int EW = PW + 2;

    // Rounding offset 2^(SOFT_SHIFT-1); a zero shift needs no offset.
    localparam logic signed [EW-1:0] RND =
        (SOFT_SHIFT > 0) ? (EW'(1) <<< ((SOFT_SHIFT > 0) ? SOFT_SHIFT - 1 : 0)) : '0;
    localparam logic signed [EW-1:0] SMAX = (EW'(1) <<< (SOFT_W - 1)) - EW'(1);
    localparam logic signed [EW-1:0] SMIN = -SMAX - EW'(1);

    typedef enum logic {ST_PRIME, ST_RUN} state_t;

    state_t r_state;
    state_t w_state_next;
    logic   w_launch;
    logic   w_load_prev;
    logic   w_clear_prev;

    logic signed [IQ_W-1:0] r_i_prev;
    logic signed [IQ_W-1:0] r_q_prev;

    logic                 r_v1;
    logic                 r_v2;
    logic signed [PW-1:0] r_pa;
    logic signed [PW-1:0] r_pb;
    logic signed [DW-1:0] r_imag;

    logic signed [PW-1:0]     w_pa;
    logic signed [PW-1:0]     w_pb;
    logic signed [DW-1:0]     w_diff;
    logic signed [EW-1:0]     w_sum;
    logic signed [EW-1:0]     w_round;
    logic                     w_hi;
    logic                     w_lo;
    logic signed [SOFT_W-1:0] w_soft;

    logic                     r_data;
    logic signed [SOFT_W-1:0] r_soft;
    logic                     r_sat;
    logic                     r_val;
    logic [CNT_W-1:0]         r_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_PRIME;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A strobe coinciding with resync becomes the new prime sample.
    always_comb begin
        w_state_next = r_state;
        w_launch     = 1'b0;
        w_load_prev  = 1'b0;
        w_clear_prev = 1'b0;
        if (resync_i) begin
            if (sym_val_i) begin
                w_load_prev  = 1'b1;
                w_state_next = ST_RUN;
            end else begin
                w_clear_prev = 1'b1;
                w_state_next = ST_PRIME;
            end
        end else if (sym_val_i) begin
            w_load_prev  = 1'b1;
            w_state_next = ST_RUN;
            w_launch     = (r_state == ST_RUN);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_i_prev <= '0;
            r_q_prev <= '0;
        end else if (w_load_prev) begin
            r_i_prev <= i_in;
            r_q_prev <= q_in;
        end else if (w_clear_prev) begin
            r_i_prev <= '0;
            r_q_prev <= '0;
        end
    end

    // Both operands sign-extended to PW bits; the product fits exactly.
    assign w_pa   = PW'(q_in) * PW'(r_i_prev);
    assign w_pb   = PW'(i_in) * PW'(r_q_prev);
    assign w_diff = DW'(r_pa) - DW'(r_pb);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_v1   <= 1'b0;
            r_v2   <= 1'b0;
            r_pa   <= '0;
            r_pb   <= '0;
            r_imag <= '0;
        end else begin
            r_v1   <= w_launch;
            r_pa   <= w_pa;
            r_pb   <= w_pb;
            r_v2   <= r_v1;
            r_imag <= (INVERT != 0) ? -w_diff : w_diff;
        end
    end

    assign w_sum   = EW'(r_imag) + RND;
    assign w_round = w_sum >>> SOFT_SHIFT;
    assign w_hi    = (w_round > SMAX);
    assign w_lo    = (w_round < SMIN);

    always_comb begin
        w_soft = w_round[SOFT_W-1:0];
        if (w_hi) begin
            w_soft = SMAX[SOFT_W-1:0];
        end else if (w_lo) begin
            w_soft = SMIN[SOFT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data <= 1'b0;
            r_soft <= '0;
            r_sat  <= 1'b0;
            r_val  <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_val <= r_v2;
            if (r_v2) begin
                r_data <= ~r_imag[DW-1];
                r_soft <= w_soft;
                r_sat  <= w_hi | w_lo;
                r_cnt  <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign data_out  = r_data;
    assign soft_out  = r_soft;
    assign sat_o     = r_sat;
    assign data_val  = r_val;
    assign sym_cnt_o = r_cnt;

endmodule

// File: tb/tb_msk_demod_diff.sv
// Bench for msk_demod_diff: default, INVERT=1 and CNT_W=4 instances share one stimulus
// and one scoreboard of expected symbols keyed by the cycle they must appear in.
module tb_msk_demod_diff;

    logic clk;
    logic reset_n;
    logic sym_val_i;
    logic resync_i;
    logic signed [15:0] i_in;
    logic signed [15:0] q_in;

    logic       d0, d1, d2;
    logic [7:0] s0, s1, s2;
    logic       t0, t1, t2;
    logic       v0, v1, v2;
    logic [15:0] c0, c1;
    logic [3:0]  c2;

    msk_demod_diff u_d0 (
        .clk(clk), .reset_n(reset_n), .sym_val_i(sym_val_i), .i_in(i_in), .q_in(q_in),
        .resync_i(resync_i), .data_out(d0), .soft_out(s0), .sat_o(t0), .data_val(v0),
        .sym_cnt_o(c0));

    msk_demod_diff #(.INVERT(1)) u_d1 (
        .clk(clk), .reset_n(reset_n), .sym_val_i(sym_val_i), .i_in(i_in), .q_in(q_in),
        .resync_i(resync_i), .data_out(d1), .soft_out(s1), .sat_o(t1), .data_val(v1),
        .sym_cnt_o(c1));

    msk_demod_diff #(.CNT_W(4)) u_d2 (
        .clk(clk), .reset_n(reset_n), .sym_val_i(sym_val_i), .i_in(i_in), .q_in(q_in),
        .resync_i(resync_i), .data_out(d2), .soft_out(s2), .sat_o(t2), .data_val(v2),
        .sym_cnt_o(c2));

    typedef struct packed {
        logic       d;
        logic [7:0] s;
        logic       t;
    } res_t;

    typedef struct {
        int unsigned cyc;
        res_t        n;
        res_t        inv;
        logic [15:0] cnt;
        logic [3:0]  cnt4;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    bit   due;

    int unsigned cyc = 0;
    int total = 0;
    int bad   = 0;

    logic               m_primed;
    logic signed [15:0] m_ip, m_qp;
    logic [15:0]        m_cnt;
    logic [3:0]         m_cnt4;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    function automatic res_t model(input logic signed [15:0] i, input logic signed [15:0] q,
                                   input logic signed [15:0] ip, input logic signed [15:0] qp,
                                   input bit inv);
        res_t   r;
        longint imag;
        longint rr;
        imag = longint'(q) * longint'(ip) - longint'(i) * longint'(qp);
        if (inv) imag = -imag;
        rr  = (imag + 64'sd8388608) >>> 24;
        r.d = (imag >= 0);
        r.t = 1'b0;
        if (rr > 127) begin
            r.s = 8'h7F;
            r.t = 1'b1;
        end else if (rr < -128) begin
            r.s = 8'h80;
            r.t = 1'b1;
        end else begin
            r.s = rr[7:0];
        end
        return r;
    endfunction

    function automatic void model_reset();
        sb.delete();
        m_primed = 1'b0;
        m_ip     = '0;
        m_qp     = '0;
        m_cnt    = '0;
        m_cnt4   = '0;
    endfunction

    // Called just after a rising edge; inputs are sampled at the next one.
    task automatic cycle(input logic sv, input logic signed [15:0] i,
                         input logic signed [15:0] q, input logic rs);
        exp_t x;
        sym_val_i = sv;
        i_in      = i;
        q_in      = q;
        resync_i  = rs;
        if (rs) begin
            m_primed = sv;
            m_ip     = sv ? i : 16'sd0;
            m_qp     = sv ? q : 16'sd0;
        end else if (sv) begin
            if (m_primed) begin
                m_cnt  = m_cnt + 16'd1;
                m_cnt4 = m_cnt4 + 4'd1;
                x.cyc  = cyc + 3;
                x.n    = model(i, q, m_ip, m_qp, 1'b0);
                x.inv  = model(i, q, m_ip, m_qp, 1'b1);
                x.cnt  = m_cnt;
                x.cnt4 = m_cnt4;
                sb.push_back(x);
            end
            m_ip     = i;
            m_qp     = q;
            m_primed = 1'b1;
        end
        @(posedge clk);
        #1;
        sym_val_i = 1'b0;
        resync_i  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 16'sd0, 16'sd0, 1'b0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_v0"}, v0, 1'b0);
        chk({tag, "_d0"}, d0, 1'b0);
        chk({tag, "_s0"}, s0, 8'h00);
        chk({tag, "_t0"}, t0, 1'b0);
        chk({tag, "_c0"}, c0, 16'h0000);
        chk({tag, "_c2"}, c2, 4'h0);
        chk({tag, "_s1"}, s1, 8'h00);
    endtask

    task automatic do_reset();
        #1;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk_zero("async_rst");
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            chk("lost_sym", 64'(cyc), 64'(sb[0].cyc));
            void'(sb.pop_front());
        end
        due = (sb.size() > 0) && (sb[0].cyc == cyc);
        chk("val0", v0, due);
        chk("val1", v1, due);
        chk("val2", v2, due);
        if (due) begin
            e = sb.pop_front();
            $display("sym cyc=%0d data=%0b soft=%0d sat=%0b cnt=%0d | inv data=%0b soft=%0d sat=%0b",
                     cyc, d0, $signed(s0), t0, c0, d1, $signed(s1), t1);
            chk("data0", d0, e.n.d);
            chk("soft0", s0, e.n.s);
            chk("sat0",  t0, e.n.t);
            chk("cnt0",  c0, e.cnt);
            chk("data1", d1, e.inv.d);
            chk("soft1", s1, e.inv.s);
            chk("sat1",  t1, e.inv.t);
            chk("cnt1",  c1, e.cnt);
            chk("soft2", s2, e.n.s);
            chk("cnt2",  c2, e.cnt4);
        end
    end

    initial begin
        sym_val_i = 1'b0;
        resync_i  = 1'b0;
        i_in      = '0;
        q_in      = '0;
        reset_n   = 1'b1;
        model_reset();
        #1;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        reset_n = 1'b1;
        idle(2);

        // Prime then +90 degree rotation, zero cross product, and another +90.
        cycle(1'b1, 16'sd16384, 16'sd0, 1'b0);
        idle(3);
        cycle(1'b1, 16'sd0, 16'sd16384, 1'b0);
        idle(4);
        cycle(1'b1, 16'sd0, -16'sd16384, 1'b0);
        idle(4);
        cycle(1'b1, 16'sd16384, 16'sd0, 1'b0);
        idle(4);

        // Large-magnitude pair driving the soft value into clipping.
        cycle(1'b1, 16'sd32767, 16'sd32767, 1'b0);
        idle(4);
        cycle(1'b1, -16'sd32768, 16'sd32767, 1'b0);
        idle(4);

        // Resync between strobes: next strobe only re-primes.
        cycle(1'b0, 16'sd0, 16'sd0, 1'b1);
        idle(1);
        cycle(1'b1, 16'sd1000, -16'sd20000, 1'b0);
        idle(4);
        cycle(1'b1, -16'sd15000, 16'sd9000, 1'b0);
        idle(4);

        // Resync coincident with a strobe: that sample becomes prev.
        cycle(1'b1, 16'sd12345, 16'sd23456, 1'b1);
        idle(2);
        cycle(1'b1, -16'sd30000, 16'sd4000, 1'b0);
        idle(4);

        // Back-to-back random strobes from a fresh reset.
        do_reset();
        for (int k = 0; k < 1000; k++) begin
            cycle(1'b1, 16'($urandom), 16'($urandom), 1'b0);
        end
        idle(5);
        chk("cnt_999", c0, 16'd999);
        chk("cnt4_wrap", c2, 4'(999 % 16));

        // Reset one cycle after a strobe: the in-flight symbol must vanish.
        cycle(1'b1, 16'sd20000, -16'sd7000, 1'b0);
        do_reset();
        idle(5);
        cycle(1'b1, 16'sd16384, 16'sd0, 1'b0);
        idle(3);
        cycle(1'b1, 16'sd0, 16'sd16384, 1'b0);
        idle(6);
        chk("cnt_after_rst", c0, 16'd1);
        chk("drained", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
